// File: rtl/comm_pkg.sv
// Shared types and default widths for the ROM-fetch / RAM-store FSM pair.
package comm_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    WAIT      = 2'd2,
    FINISH    = 2'd3
  } state_t;

endpackage

// File: rtl/fsm_store_ram_if.sv
// Start/finish handshake plus RAM write port of the store FSM.
interface fsm_store_ram_if #(
  parameter int ADDR_W = comm_pkg::ADDR_W_DEF,
  parameter int DATA_W = comm_pkg::DATA_W_DEF
);

  logic              start;
  logic              clear;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address_for_RAM;
  logic [DATA_W-1:0] data_to_RAM;
  logic              wren;
  logic              finish;
  logic              overflow;
  logic              full;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, clear, data_in,
    input  address_for_RAM, data_to_RAM, wren, finish, overflow, full, word_count
  );

  modport slave (
    input  start, clear, data_in,
    output address_for_RAM, data_to_RAM, wren, finish, overflow, full, word_count
  );

endinterface

// File: rtl/fsm_store_ram_wr_addr_counter.sv
// Write pointer and written-word count with wrap-or-saturate behaviour at DEPTH-1.
module wr_addr_counter #(
  parameter int ADDR_W = comm_pkg::ADDR_W_DEF,
  parameter int DEPTH  = 65536,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (inc) begin
      if (ptr == LAST) begin
        if (WRAP != 0) ptr  <= '0;
        else           full <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
      end
      // count wraps naturally when WRAP=1; otherwise it stops at DEPTH
      if ((WRAP != 0) || (count != CNT_MAX))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_store_ram.sv
// Store FSM: one start/finish handshake writes one word to RAM at an auto-incrementing address.
//
// state     | meaning
// IDLE      | wait for start or clear
// SEND_ADDR | wren high, address/data presented to RAM
// WAIT      | wren low, address/data held for RAM settle
// FINISH    | finish pulse (with overflow if refused); pointer advances on exit
module fsm_store_ram
  import comm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 65536,
  parameter int WRAP   = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  fsm_store_ram_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              wren_q;
  logic              finish_q;
  logic              overflow_q;
  logic              wrote_q;

  logic              cnt_inc;
  logic              cnt_clear;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              full;

  assign cnt_clear = (state == IDLE) && bus.clear;
  assign cnt_inc   = (state == FINISH) && wrote_q;

  wr_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WRAP   (WRAP)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cnt_inc),
    .clear   (cnt_clear),
    .ptr     (ptr),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_q     <= '0;
      wren_q     <= 1'b0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
      wrote_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wren_q     <= 1'b0;
          finish_q   <= 1'b0;
          overflow_q <= 1'b0;
          // clear takes priority and swallows a coincident start
          if (!bus.clear && bus.start) begin
            if (full) begin
              state      <= FINISH;
              finish_q   <= 1'b1;
              overflow_q <= 1'b1;
              wrote_q    <= 1'b0;
            end else begin
              state   <= SEND_ADDR;
              data_q  <= bus.data_in;
              wren_q  <= 1'b1;
              wrote_q <= 1'b1;
            end
          end
        end
        SEND_ADDR: begin
          wren_q <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          finish_q <= 1'b1;
          state    <= FINISH;
        end
        FINISH: begin
          finish_q   <= 1'b0;
          overflow_q <= 1'b0;
          wrote_q    <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          wren_q     <= 1'b0;
          finish_q   <= 1'b0;
          overflow_q <= 1'b0;
          wrote_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address_for_RAM = ptr;
  assign bus.data_to_RAM     = data_q;
  assign bus.wren            = wren_q;
  assign bus.finish          = finish_q;
  assign bus.overflow        = overflow_q;
  assign bus.full            = full;
  assign bus.word_count      = count;

endmodule

// File: tb/tb_fsm_store_ram.sv
// Directed bench: three store FSMs (default, DEPTH=4 saturating, DEPTH=4 wrapping) on shared stimulus.
module tb_fsm_store_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [31:0] data_in;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_store_ram_if #(.ADDR_W(16), .DATA_W(32)) if_a ();
  fsm_store_ram_if #(.ADDR_W(16), .DATA_W(32)) if_b ();
  fsm_store_ram_if #(.ADDR_W(16), .DATA_W(32)) if_c ();

  assign if_a.start = start;  assign if_a.clear = clear;  assign if_a.data_in = data_in;
  assign if_b.start = start;  assign if_b.clear = clear;  assign if_b.data_in = data_in;
  assign if_c.start = start;  assign if_c.clear = clear;  assign if_c.data_in = data_in;

  fsm_store_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(65536), .WRAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  fsm_store_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .WRAP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  fsm_store_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .WRAP(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  // RAM models and write-pulse counters
  logic [31:0] ram_a [16];
  logic [31:0] ram_b [16];
  logic [31:0] ram_c [16];
  logic [15:0] log_c [32];
  int n_a = 0, n_b = 0, n_c = 0;

  always @(posedge clk) begin : ram_model
    if (if_a.wren === 1'b1) begin ram_a[if_a.address_for_RAM[3:0]] = if_a.data_to_RAM; n_a++; end
    if (if_b.wren === 1'b1) begin ram_b[if_b.address_for_RAM[3:0]] = if_b.data_to_RAM; n_b++; end
    if (if_c.wren === 1'b1) begin
      ram_c[if_c.address_for_RAM[3:0]] = if_c.data_to_RAM;
      if (n_c < 32) log_c[n_c] = if_c.address_for_RAM;
      n_c++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d);
    data_in = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    tick();
  endtask

  int base_a, base_b, base_c;

  initial begin : stim
    reset_n = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    data_in = '0;
    for (int i = 0; i < 16; i++) begin ram_a[i] = '0; ram_b[i] = '0; ram_c[i] = '0; end
    tick();
    check("rst_wren",   64'(if_a.wren), 64'd0);
    check("rst_finish", 64'(if_a.finish), 64'd0);
    check("rst_ovf",    64'(if_b.overflow), 64'd0);
    check("rst_full",   64'(if_b.full), 64'd0);
    check("rst_addr",   64'(if_a.address_for_RAM), 64'd0);
    check("rst_data",   64'(if_a.data_to_RAM), 64'd0);
    check("rst_count",  64'(if_a.word_count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single write with latency checks
    data_in = 32'hDEADBEEF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = 32'h12345678;
    check("sw_wren1",   64'(if_a.wren), 64'd1);
    check("sw_addr",    64'(if_a.address_for_RAM), 64'd0);
    check("sw_data",    64'(if_a.data_to_RAM), 64'hDEADBEEF);
    check("sw_fin1",    64'(if_a.finish), 64'd0);
    tick();
    check("sw_wren2",   64'(if_a.wren), 64'd0);
    check("sw_fin2",    64'(if_a.finish), 64'd0);
    check("sw_hold",    64'(if_a.data_to_RAM), 64'hDEADBEEF);
    tick();
    check("sw_fin3",    64'(if_a.finish), 64'd1);
    check("sw_ovf3",    64'(if_a.overflow), 64'd0);
    check("sw_cnt3",    64'(if_a.word_count), 64'd0);
    tick();
    check("sw_fin4",    64'(if_a.finish), 64'd0);
    check("sw_count",   64'(if_a.word_count), 64'd1);
    check("sw_addr_nx", 64'(if_a.address_for_RAM), 64'd1);
    check("sw_pulses",  64'(n_a), 64'd1);
    check("sw_ram",     64'(ram_a[0]), 64'hDEADBEEF);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_addr",  64'(if_a.address_for_RAM), 64'd0);
    check("clr_count", 64'(if_a.word_count), 64'd0);

    // back-to-back writes
    base_a = n_a; base_b = n_b; base_c = n_c;
    do_write(32'h11);
    do_write(32'h22);
    do_write(32'h33);
    do_write(32'h44);
    check("b2b_pulses", 64'(n_a - base_a), 64'd4);
    check("b2b_ram0",   64'(ram_a[0]), 64'h11);
    check("b2b_ram1",   64'(ram_a[1]), 64'h22);
    check("b2b_ram2",   64'(ram_a[2]), 64'h33);
    check("b2b_ram3",   64'(ram_a[3]), 64'h44);
    check("b2b_count",  64'(if_a.word_count), 64'd4);
    check("b2b_addr",   64'(if_a.address_for_RAM), 64'd4);
    check("b2b_full_a", 64'(if_a.full), 64'd0);
    check("sat_full",   64'(if_b.full), 64'd1);
    check("sat_addr",   64'(if_b.address_for_RAM), 64'd3);
    check("sat_count",  64'(if_b.word_count), 64'd4);
    check("wrap_full4", 64'(if_c.full), 64'd0);
    check("wrap_addr4", 64'(if_c.address_for_RAM), 64'd0);

    // 5th start: saturating unit refuses, wrapping unit writes address 0
    data_in = 32'h55;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("ovf_fin",    64'(if_b.finish), 64'd1);
    check("ovf_pulse",  64'(if_b.overflow), 64'd1);
    check("ovf_wren",   64'(if_b.wren), 64'd0);
    check("ovf_a_wren", 64'(if_a.wren), 64'd1);
    tick();
    check("ovf_clr",    64'(if_b.overflow), 64'd0);
    check("ovf_fin_lo", 64'(if_b.finish), 64'd0);
    check("ovf_a_ovf",  64'(if_a.overflow), 64'd0);
    tick();
    tick();
    check("ovf_pulses", 64'(n_b - base_b), 64'd4);
    check("ovf_ram3",   64'(ram_b[3]), 64'h44);
    check("ovf_count",  64'(if_b.word_count), 64'd4);
    check("ovf_full",   64'(if_b.full), 64'd1);

    do_write(32'h66);
    check("wrap_pulses", 64'(n_c - base_c), 64'd6);
    check("wrap_log0",   64'(log_c[base_c + 0]), 64'd0);
    check("wrap_log1",   64'(log_c[base_c + 1]), 64'd1);
    check("wrap_log2",   64'(log_c[base_c + 2]), 64'd2);
    check("wrap_log3",   64'(log_c[base_c + 3]), 64'd3);
    check("wrap_log4",   64'(log_c[base_c + 4]), 64'd0);
    check("wrap_log5",   64'(log_c[base_c + 5]), 64'd1);
    check("wrap_ram0",   64'(ram_c[0]), 64'h55);
    check("wrap_ram1",   64'(ram_c[1]), 64'h66);
    check("wrap_count",  64'(if_c.word_count), 64'd6);
    check("wrap_full",   64'(if_c.full), 64'd0);
    check("wrap_addr",   64'(if_c.address_for_RAM), 64'd2);
    check("sat_count6",  64'(if_b.word_count), 64'd4);
    check("a_count6",    64'(if_a.word_count), 64'd6);

    // clear wins over a coincident start, with pointer at 3
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_write(32'hA1);
    do_write(32'hA2);
    do_write(32'hA3);
    check("cs_pre_addr", 64'(if_b.address_for_RAM), 64'd3);
    check("cs_pre_cnt",  64'(if_a.word_count), 64'd3);
    base_a = n_a;
    clear = 1'b1;
    start = 1'b1;
    data_in = 32'hBAD0;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("cs_addr",  64'(if_a.address_for_RAM), 64'd0);
    check("cs_count", 64'(if_a.word_count), 64'd0);
    check("cs_full",  64'(if_b.full), 64'd0);
    check("cs_wren",  64'(if_a.wren), 64'd0);
    tick();
    tick();
    tick();
    check("cs_fin",    64'(if_a.finish), 64'd0);
    check("cs_pulses", 64'(n_a - base_a), 64'd0);

    // async reset during SEND_ADDR
    do_write(32'h77);
    check("ar_pre_addr", 64'(if_a.address_for_RAM), 64'd1);
    data_in = 32'hA5A5;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("ar_wren_hi", 64'(if_a.wren), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_wren_a", 64'(if_a.wren), 64'd0);
    check("ar_wren_c", 64'(if_c.wren), 64'd0);
    check("ar_addr",   64'(if_a.address_for_RAM), 64'd0);
    check("ar_count",  64'(if_a.word_count), 64'd0);
    check("ar_data",   64'(if_a.data_to_RAM), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("ar_idle_fin", 64'(if_a.finish), 64'd0);

    // start held high through SEND_ADDR/WAIT/FINISH yields one write
    base_a = n_a;
    data_in = 32'hC0DE;
    start   = 1'b1;
    tick();
    check("hold_wren", 64'(if_a.wren), 64'd1);
    tick();
    tick();
    check("hold_fin", 64'(if_a.finish), 64'd1);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("hold_pulses", 64'(n_a - base_a), 64'd1);
    check("hold_count",  64'(if_a.word_count), 64'd1);
    check("hold_addr",   64'(if_a.address_for_RAM), 64'd1);
    check("hold_ram",    64'(ram_a[0]), 64'hC0DE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsm_store_ram.md
Name: fsm_store_ram

Overview:
- Write-side counterpart to the ROM-fetch FSM: accepts one data word per start/finish handshake and writes it into an on-chip single-port RAM IP block at an auto-incrementing address.
- Sits downstream of processing stages in the communication system, buffering received/processed words for later readout.
- Start/finish handshake matches the ROM-fetch FSM so the two can be chained directly.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 32, data word width.
- DEPTH, 65536, number of writable locations (≤ 2**ADDR_W).
- WRAP, 0, 1 = address wraps to 0 after DEPTH-1; 0 = stop and flag full.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request one write; sampled only in IDLE.
- clear  in  1  reset pointer/count/full; honoured only in IDLE.
- data_in  in  DATA_W  word to store; sampled on the start cycle.
- address_for_RAM  out  ADDR_W  RAM address (always = write pointer).
- data_to_RAM  out  DATA_W  latched write data.
- wren  out  1  RAM write enable.
- finish  out  1  one-cycle done pulse.
- overflow  out  1  one-cycle pulse: write refused because full.
- full  out  1  level: no free locations (WRAP=0 only).
- word_count  out  ADDR_W+1  words written since reset/clear (saturates at DEPTH when WRAP=0).

Behaviour:
- Reset (async, reset_n=0): state IDLE, pointer 0, data latch 0, word_count 0. wren, finish, overflow and full are 0 immediately, not at the next edge.
- States: IDLE, SEND_ADDR, WAIT, FINISH.
- IDLE:
  - clear=1: pointer, word_count and full go to 0; stay IDLE. clear wins over a simultaneous start, and that start is dropped.
  - start=1 and full=0: latch data_in and go to SEND_ADDR.
  - start=1 and full=1: go to FINISH with no write; overflow pulses alongside finish.
- SEND_ADDR: wren=1 for exactly this one cycle; address_for_RAM and data_to_RAM stable. Go to WAIT.
- WAIT: wren=0; address and data held for RAM settle. Go to FINISH.
- FINISH: finish=1 for one cycle. If a write occurred, the pointer and count update on the exit edge; go to IDLE.
- Latency: start sampled at edge N; wren high in cycle N+1; finish high in cycle N+3; earliest next start accepted at edge N+4.
- Pointer update on the FINISH exit edge:
  - pointer < DEPTH-1: pointer+1.
  - pointer = DEPTH-1, WRAP=1: pointer goes to 0.
  - pointer = DEPTH-1, WRAP=0: pointer holds and full is set.
- word_count increments per completed write; with WRAP=1 it wraps modulo 2**(ADDR_W+1).
- start or clear outside IDLE: ignored. No queuing.
- data_in changing after the start cycle has no effect.
- An undefined state encoding recovers to IDLE on the next edge with wren=0.
- No X on any output in any state.

Decomposition:
- Package comm_pkg: state enum typedef (IDLE, SEND_ADDR, WAIT, FINISH) and default ADDR_W/DATA_W constants shared with the ROM-fetch FSM.
- One natural sub-module, wr_addr_counter: pointer plus word_count with the wrap/full logic, taking inputs inc, clear, and parameters DEPTH/WRAP.
- Top level keeps the FSM and output decode.

Test Plan:
- Reset, then single write: start=1 with data_in=32'hDEADBEEF -> wren=1 one cycle later with address_for_RAM=0 and data_to_RAM=DEADBEEF; finish high exactly 3 cycles after start; word_count=1; address_for_RAM=1 afterwards.
- Back-to-back: 4 writes of 0x11,0x22,0x33,0x44, each start issued on the cycle after finish -> RAM model holds 0x11..0x44 at addresses 0..3; exactly 4 wren pulses; word_count=4.
- Full/overflow (DEPTH=4, WRAP=0): 5 starts -> 4th finish sets full=1; 5th start gives finish+overflow with no wren; RAM address 3 unchanged.
- Wrap (DEPTH=4, WRAP=1): 6 writes -> addresses 0,1,2,3,0,1; full stays 0; word_count=6.
- Clear and start in the same IDLE cycle with pointer=3 -> pointer=0, word_count=0, full=0; no wren, no finish.
- Async reset asserted during SEND_ADDR -> wren drops to 0 within the same cycle before any edge; after release the FSM is IDLE with pointer=0, and start mid-operation is ignored (start held high during WAIT causes no extra write).
